// File: rtl/pixel_tx_pkg.sv
// Shared definitions for the WS2812B pixel transmitter: FSM states,
// default timing constants and the channel-capture helper.
// Optional feature macro: PIXEL_TX_DIM_EN (divide each channel by 4 at capture).
package pixel_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SEND   = 2'd2
    } state_e;

    localparam int BIT_CYCLES = 15;
    localparam int T0H_CYCLES = 5;
    localparam int T1H_CYCLES = 10;
    localparam int PIXEL_BITS = 24;

    // Builds the on-wire word: green first, then red, then blue.
    function automatic logic [23:0] pack_grb(input logic [7:0] g,
                                             input logic [7:0] r,
                                             input logic [7:0] b);
`ifdef PIXEL_TX_DIM_EN
        return {2'b00, g[7:2], 2'b00, r[7:2], 2'b00, b[7:2]};
`else
        return {g, r, b};
`endif
    endfunction

endpackage

// File: rtl/pixel_tx_ws_bit_encoder.sv
// WS2812B bit encoder: from a phase count and the bit value, decides the
// line level for that phase and flags the last phase of the bit period.
module ws_bit_encoder #(
    parameter int BIT_CYCLES = 15,
    parameter int T0H_CYCLES = 5,
    parameter int T1H_CYCLES = 10,
    parameter int PW         = 4
) (
    input  logic [PW-1:0] phase_i,
    input  logic          bit_i,
    output logic          high_o,
    output logic          bit_end_o
);

    localparam logic [PW-1:0] T0H_P  = PW'(T0H_CYCLES);
    localparam logic [PW-1:0] T1H_P  = PW'(T1H_CYCLES);
    localparam logic [PW-1:0] LAST_P = PW'(BIT_CYCLES - 1);

    // Level and end-of-bit decode for the given phase.
    always_comb begin
        high_o    = 1'b0;
        bit_end_o = 1'b0;
        if (bit_i) begin
            high_o = (phase_i < T1H_P);
        end else begin
            high_o = (phase_i < T0H_P);
        end
        bit_end_o = (phase_i == LAST_P);
    end

endmodule

// File: rtl/pixel_tx.sv
// WS2812B single-pixel transmitter: captures a GRB pixel, then shifts it
// out MSB first as 24 pulse-width-coded bits while transmit_pixel is held.
// Optional feature macro: PIXEL_TX_DIM_EN (see pixel_tx_pkg::pack_grb).
module pixel_tx #(
    parameter int BIT_CYCLES = pixel_tx_pkg::BIT_CYCLES,
    parameter int T0H_CYCLES = pixel_tx_pkg::T0H_CYCLES,
    parameter int T1H_CYCLES = pixel_tx_pkg::T1H_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    input  logic       load_sreg,
    input  logic       transmit_pixel,
    output logic       dout,
    output logic       busy,
    output logic       pixel_done,
    output logic       underrun
);

    import pixel_tx_pkg::*;

    localparam int              PW     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [PW-1:0]   PH_ONE = PW'(1);
    localparam logic [4:0]      TOP_BIT = 5'(PIXEL_BITS - 1);

    state_e        state_q, state_d;
    logic [23:0]   sreg_q, sreg_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [4:0]    bit_q, bit_d;
    logic          bit_end_q, bit_end_d;
    logic          dout_q, dout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          underrun_q, underrun_d;
    logic          enc_high_s;
    logic          enc_end_s;

    // The encoder looks at the upcoming phase/bit so dout can be registered
    // and still rise on the very edge that enters SEND.
    ws_bit_encoder #(
        .BIT_CYCLES (BIT_CYCLES),
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES),
        .PW         (PW)
    ) u_enc (
        .phase_i   (phase_d),
        .bit_i     (sreg_d[bit_d]),
        .high_o    (enc_high_s),
        .bit_end_o (enc_end_s)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        case (state_q)
            IDLE: begin
                if (load_sreg) begin
                    sreg_d  = pack_grb(green, red, blue);
                    state_d = LOADED;
                end else if (transmit_pixel) begin
                    underrun_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOADED: begin
                if (load_sreg) begin
                    sreg_d = pack_grb(green, red, blue);
                end else begin
                    sreg_d = sreg_q;
                end
                if (transmit_pixel) begin
                    state_d = SEND;
                    phase_d = '0;
                    bit_d   = TOP_BIT;
                end else begin
                    state_d = LOADED;
                end
            end
            SEND: begin
                // Loads are ignored here; the shift register is frozen.
                if (!transmit_pixel) begin
                    state_d = IDLE;
                    phase_d = '0;
                    bit_d   = 5'd0;
                end else if (bit_end_q) begin
                    phase_d = '0;
                    if (bit_q == 5'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q - 5'd1;
                    end
                end else begin
                    phase_d = phase_q + PH_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
                bit_d   = 5'd0;
            end
        endcase
        busy_d    = (state_d == SEND);
        dout_d    = (state_d == SEND) && enc_high_s;
        bit_end_d = (state_d == SEND) && enc_end_s;
    end

    // State and registered outputs; rst wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sreg_q     <= 24'd0;
            phase_q    <= '0;
            bit_q      <= 5'd0;
            bit_end_q  <= 1'b0;
            dout_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            bit_end_q  <= bit_end_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign dout       = dout_q;
    assign busy       = busy_q;
    assign pixel_done = done_q;
    assign underrun   = underrun_q;

endmodule
